// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed seven-segment driver with tear-free double-buffered digits
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter bit COMMON_ANODE = 0,
    parameter bit HEX_MODE = 1,
    parameter bit LEADING_ZERO_BLANK = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              sout,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = 5 * NUM_DIGITS;

    logic [PW-1:0]         pc_q, pc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         shadow_q, shadow_d, active_q, active_d;
    logic [6:0]            sout_q, sout_d, seg;
    logic                  dp_q, dp_d, frame_done_q, frame_done_d;
    logic                  tick, wrap, blank, dp_l, zero_run;
    logic [NUM_DIGITS-1:0] sel_q, sel_d, sel_l;
    logic [3:0]            code;

    function automatic logic [6:0] decode(input logic [3:0] c);
        case (c)
            4'h0: decode = 7'h7E;
            4'h1: decode = 7'h30;
            4'h2: decode = 7'h6D;
            4'h3: decode = 7'h79;
            4'h4: decode = 7'h33;
            4'h5: decode = 7'h5B;
            4'h6: decode = 7'h5F;
            4'h7: decode = 7'h70;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h7B;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h1F;
            4'hC: decode = 7'h4E;
            4'hD: decode = 7'h3D;
            4'hE: decode = 7'h4F;
            default: decode = 7'h47;
        endcase
    endfunction

    always_comb begin
        tick = enable && pc_q == PW'(PRESCALE - 1);
        wrap = tick && idx_q == IW'(NUM_DIGITS - 1);
        pc_d = !enable ? pc_q : tick ? '0 : pc_q + 1'b1;
        idx_d = !tick ? idx_q : wrap ? '0 : idx_q + 1'b1;
        shadow_d = load ? {value, dp_in} : shadow_q;
        active_d = wrap ? shadow_d : active_q;
        frame_done_d = wrap;
        code = '0;
        dp_l = 1'b0;
        blank = 1'b0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && active_q[NUM_DIGITS + 4*i +: 4] == 4'd0;
            sel_l[i] = idx_q == IW'(i);
            if (sel_l[i]) begin
                code = active_q[NUM_DIGITS + 4*i +: 4];
                dp_l = active_q[i];
                blank = zero_run && i != 0;
            end
        end
        seg = (LEADING_ZERO_BLANK && blank) || (!HEX_MODE && code > 4'd9) ? 7'h00 : decode(code);
        sout_d = {7{COMMON_ANODE}} ^ (enable ? seg : 7'h00);
        dp_d = COMMON_ANODE ^ (enable && dp_l);
        sel_d = {NUM_DIGITS{!COMMON_ANODE}} ^ (enable ? sel_l : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
            idx_q <= '0;
            shadow_q <= '0;
            active_q <= '0;
            sout_q <= {7{COMMON_ANODE}};
            dp_q <= COMMON_ANODE;
            sel_q <= {NUM_DIGITS{!COMMON_ANODE}};
            frame_done_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            idx_q <= idx_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            sout_q <= sout_d;
            dp_q <= dp_d;
            sel_q <= sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sout = sout_q;
    assign dp = dp_q;
    assign digit_sel = sel_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: random stimulus on four configurations checked against a frame-arithmetic model
module tb_seven_seg_scan_driver;
    localparam int NS [4] = '{4, 4, 3, 1};
    localparam int PS [4] = '{4, 3, 1, 2};
    localparam bit CAS [4] = '{0, 1, 0, 1};
    localparam bit HXS [4] = '{1, 0, 1, 1};
    localparam bit LZS [4] = '{0, 1, 1, 0};
    localparam logic [6:0] SEG [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic clk = 1'b0;
    logic rst, enable, load, run;
    logic [15:0] value;
    logic [3:0] dp_in;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int N = NS[g];
        localparam int P = PS[g];
        localparam bit CA = CAS[g];
        localparam bit HX = HXS[g];
        localparam bit LZ = LZS[g];
        logic [6:0] sout, e_sout;
        logic dp, fd, e_dp, e_fd;
        logic [N-1:0] sel, e_sel;

        seven_seg_scan_driver #(
            .NUM_DIGITS(N), .PRESCALE(P), .COMMON_ANODE(CA), .HEX_MODE(HX), .LEADING_ZERO_BLANK(LZ)
        ) u_dut (
            .clk(clk), .rst(rst), .enable(enable), .load(load),
            .value(value[4*N-1:0]), .dp_in(dp_in[N-1:0]),
            .sout(sout), .dp(dp), .digit_sel(sel), .frame_done(fd)
        );

        initial begin
            int cnt, d;
            logic [15:0] sh_v, ac_v, vm;
            logic [3:0] sh_d, ac_d, dm, c;
            logic [6:0] sl;
            logic dl, blk;
            logic [N-1:0] ll;
            vm = 16'((32'h1 << (4*N)) - 1);
            dm = 4'((32'h1 << N) - 1);
            forever begin
                @(posedge clk);
                if (rst) begin
                    cnt = 0; sh_v = 0; sh_d = 0; ac_v = 0; ac_d = 0;
                    e_sout = CA ? 7'h7F : 7'h00;
                    e_dp = CA;
                    e_sel = CA ? '0 : '1;
                    e_fd = 1'b0;
                end else begin
                    d = (cnt / P) % N;
                    c = 4'(ac_v >> (4*d));
                    blk = LZ && d > 0 && (ac_v >> (4*d)) == 16'h0;
                    sl = (!enable || blk || (c > 4'd9 && !HX)) ? 7'h00 : SEG[c];
                    dl = enable && ac_d[d];
                    ll = enable ? N'(1 << d) : '0;
                    e_sout = CA ? ~sl : sl;
                    e_dp = CA ? ~dl : dl;
                    e_sel = CA ? ll : ~ll;
                    e_fd = enable && (cnt % (N*P)) == N*P - 1;
                    if (e_fd) begin
                        ac_v = load ? value & vm : sh_v;
                        ac_d = load ? dp_in & dm : sh_d;
                    end
                    if (load) begin
                        sh_v = value & vm;
                        sh_d = dp_in & dm;
                    end
                    if (enable) cnt++;
                end
            end
        end

        always @(negedge clk) if (run) begin
            chk($sformatf("u%0d.sout", g), 32'(sout), 32'(e_sout));
            chk($sformatf("u%0d.dp", g), 32'(dp), 32'(e_dp));
            chk($sformatf("u%0d.digit_sel", g), 32'(sel), 32'(e_sel));
            chk($sformatf("u%0d.frame_done", g), 32'(fd), 32'(e_fd));
        end
    end

    task automatic load_and_scan(input logic [15:0] v, input logic [3:0] d, input int cycles);
        load = 1'b1; value = v; dp_in = d;
        @(negedge clk);
        load = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        logic [15:0] pats [5];
        pats = '{16'h1234, 16'h00AF, 16'h0070, 16'h0000, 16'h8888};
        rst = 1'b1; enable = 1'b1; load = 1'b0; value = '0; dp_in = '0; run = 1'b0;
        repeat (3) @(negedge clk);
        run = 1'b1;
        chk("reset sout", 32'(g_dut[0].sout), 32'h00);
        chk("reset dp", 32'(g_dut[0].dp), 32'h0);
        chk("reset digit_sel", 32'(g_dut[0].sel), 32'hF);
        chk("reset frame_done", 32'(g_dut[0].fd), 32'h0);
        chk("reset ca sout", 32'(g_dut[1].sout), 32'h7F);
        chk("reset ca digit_sel", 32'(g_dut[1].sel), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("release sout", 32'(g_dut[0].sout), 32'h7E);
        chk("release digit_sel", 32'(g_dut[0].sel), 32'hE);
        load_and_scan(pats[0], 4'b0010, 40);
        load_and_scan(pats[1], 4'b0000, 40);
        load_and_scan(pats[2], 4'b0101, 40);
        load_and_scan(pats[3], 4'b1000, 40);
        load_and_scan(pats[4], 4'b0001, 40);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        repeat (6000) begin
            rst = $urandom_range(0, 399) == 0;
            enable = $urandom_range(0, 15) != 0;
            load = $urandom_range(0, 7) == 0;
            value = 16'($urandom) & 16'((32'h1 << (4 * $urandom_range(0, 4))) - 1);
            dp_in = 4'($urandom);
            @(negedge clk);
        end
        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
